extra_table_lookup: RTL
=======================

Name: extra_table_lookup

Overview:
- Read-side consumer of the 512x19 extra table RAM: a simple dual-port RAM with a 1-cycle read latency, no output register.
- Accepts keyed lookup requests on a valid/ready stream and drives the RAM read address.
- Realigns the RAM read data with each request's tag and returns in-order responses on a backpressurable valid/ready stream.
- Sits between the packet-field extractor (upstream) and the table RAM read port (downstream of it).

Parameters:
- ADDR_WIDTH, 9, RAM read address width.
- DATA_WIDTH, 19, RAM read data width.
- TAG_WIDTH, 8, width of the opaque tag carried from request to response.
- TABLE_DEPTH, 512, number of valid entries; keys >= TABLE_DEPTH are out of range.

Ports:
- clk  in  1  single clock; also drives the RAM rd_clk.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  lookup request accepted when high with req_valid.
- req_key  in  ADDR_WIDTH  table index.
- req_tag  in  TAG_WIDTH  request tag.
- rd_addr  out  ADDR_WIDTH  to the RAM rd_addr.
- rd_data  in  DATA_WIDTH  from the RAM rd_data; valid one cycle after the address is sampled.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_WIDTH  looked-up entry; 0 on error.
- rsp_tag  out  TAG_WIDTH  tag of the matching request.
- rsp_err  out  1  key was out of range.
- busy  out  1  request in flight or response FIFO non-empty.

Behaviour:
- Reset (rst_n low, async) clears:
  - response FIFO (3 entries) and its pointers;
  - the in-flight flag and the last-address register;
  - all outputs to 0: rsp_valid, rsp_data, rsp_tag, rsp_err, rd_addr, busy, req_ready.
- req_ready goes 1 in the first cycle after rst_n deasserts.
- req_ready = (fifo_count + inflight) < 3.
  - Derived from registered state only; no combinational path from rsp_ready.
- Accept = req_valid & req_ready.
  - rd_addr = req_key combinationally in the accept cycle; otherwise rd_addr holds the last accepted key (registered).
- Request accepted at edge E0:
  - RAM samples rd_addr at E0.
  - inflight is set, with the tag and err bit stored in a one-deep pipe register.
  - At E1 the FIFO writes {rd_data or 0 if err, tag, err}.
  - rsp_valid is high in the cycle after E1, so latency from accept to rsp_valid = 2 edges.
- err = (req_key >= TABLE_DEPTH), computed at accept.
  - An out-of-range request still occupies a slot and returns in order.
  - rsp_data is forced to 0 when err = 1.
- Response FIFO:
  - first-word-fall-through; rsp_* are driven from the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle leave count unchanged.
- Pointers are 2-bit mod-3 counters; wrap 2 -> 0.
- Overflow is impossible by construction; the bench asserts that push never occurs while count = 3.
- Steady state with rsp_ready held 1: one request accepted per cycle, count = 1, inflight = 1.
- Backpressure: with rsp_ready = 0, at most 3 requests are accepted; req_ready then stays 0 until a pop.
- rsp_* are stable while rsp_valid = 1 and rsp_ready = 0.
- busy = inflight | (fifo_count != 0).
- Reset mid-operation: in-flight and buffered responses are discarded; no response is emitted after reset.

Optional Feature:
- Macro: EXTRA_TABLE_LOOKUP_STAT_EN.
- When defined, adds three outputs:
  - stat_req_cnt [31:0]: increments on every accept;
  - stat_err_cnt [31:0]: increments on every accept with err = 1;
  - stat_stall_cnt [15:0]: increments every cycle with rsp_valid = 1 and rsp_ready = 0.
- All three reset to 0, saturate at all-ones and do not wrap.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then RAM preloaded with addr*3; single request key = 5, tag = 0x11 with rsp_ready = 1 -> rsp_valid exactly 2 edges after accept, rsp_data = 15, rsp_tag = 0x11, rsp_err = 0, busy drops the cycle after the pop.
- Back-to-back: 16 requests with keys 0..15 and rsp_ready = 1 -> req_ready never drops, 16 in-order responses on consecutive cycles, data = key*3.
- Backpressure: rsp_ready = 0, 5 requests offered -> exactly 3 accepted and req_ready = 0; head response held stable; rsp_ready = 1 -> remaining 2 requests accepted, all 5 delivered in order.
- TABLE_DEPTH = 300, key = 300 and key = 511 interleaved with key = 299 -> err responses have rsp_data = 0, rsp_err = 1; key 299 returns 897; ordering preserved. With EXTRA_TABLE_LOOKUP_STAT_EN: stat_err_cnt = 2, stat_req_cnt = 3.
- Pointer wrap: 10 requests with rsp_ready toggling every cycle -> all 10 correct and in order; FIFO pointers wrap at least 3 times.
- Assert rst_n low for 1 cycle with 2 responses buffered and 1 in flight -> all rsp_* = 0 immediately; no response afterwards; req_ready = 1 in the first cycle after release.

Source files
------------

// File: rtl/extra_table_lookup.sv
// Keyed lookup front-end for the 512x19 extra table RAM: issues reads, realigns data with tags,
// returns in-order responses through a 3-entry FWFT FIFO. Optional counters: EXTRA_TABLE_LOOKUP_STAT_EN.
module extra_table_lookup #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 19,
  parameter int TAG_WIDTH   = 8,
  parameter int TABLE_DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_key,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err,
  output logic                  busy
`ifdef EXTRA_TABLE_LOOKUP_STAT_EN
  ,
  output logic [31:0]           stat_req_cnt,
  output logic [31:0]           stat_err_cnt,
  output logic [15:0]           stat_stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  err;
  } entry_t;

  entry_t                mem [3];
  entry_t                head;
  logic [1:0]            wr_ptr, rd_ptr, count;
  logic                  inflight, ready_en;
  logic [TAG_WIDTH-1:0]  pipe_tag;
  logic                  pipe_err;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [2:0]            occupancy;
  logic                  accept, key_err, push, pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Every accepted request holds a slot from accept until pop, so this can never exceed 3.
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign req_ready = ready_en & (occupancy < 3'd3);
  assign accept    = req_valid & req_ready;
  assign key_err   = 32'(req_key) >= TABLE_DEPTH;
  assign rd_addr   = accept ? req_key : last_addr;

  assign push      = inflight;
  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = inflight | (count != 2'd0);

  // NOTE: the FIFO storage has no reset; outputs are gated by rsp_valid so stale entries never leak out.
  assign head      = mem[rd_ptr];
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_tag   = rsp_valid ? head.tag  : '0;
  assign rsp_err   = rsp_valid & head.err;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: pipe_err ? '0 : rd_data, tag: pipe_tag, err: pipe_err};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      inflight  <= 1'b0;
      pipe_tag  <= '0;
      pipe_err  <= 1'b0;
      last_addr <= '0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 2'd0;
    end else begin
      ready_en <= 1'b1;
      inflight <= accept;
      if (accept) begin
        pipe_tag  <= req_tag;
        pipe_err  <= key_err;
        last_addr <= req_key;
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef EXTRA_TABLE_LOOKUP_STAT_EN
  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req_cnt   <= '0;
      stat_err_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (accept && (stat_req_cnt != '1)) stat_req_cnt <= stat_req_cnt + 32'd1;
      if (accept && key_err && (stat_err_cnt != '1)) stat_err_cnt <= stat_err_cnt + 32'd1;
      if (rsp_valid && !rsp_ready && (stat_stall_cnt != '1)) stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
